dmem_arbiter: RTL

- Two-port arbiter and sequencer for the single-ported 256x16 data memory.
- Requester 0 is the CPU load/store stage; requester 1 is a secondary master (DMA/debug loader).
- Grants one requester per transaction using round-robin or fixed priority, then drives the memory's mem_read/mem_write/address/write_data for one cycle.
- Registers the read data and returns it with a one-cycle response strobe.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_arbiter_rr_pick2.sv | 25 ++
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared widths, FSM states and arbitration mode constants for the data-memory arbiter.
package dmem_pkg;

   localparam int unsigned ADDR_W_DEF = 8;
   localparam int unsigned DATA_W_DEF = 16;

   localparam int unsigned PRIO_RR    = 0;
   localparam int unsigned PRIO_FIXED = 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way winner select: round-robin against last owner, or fixed priority to requester 0.
module rr_pick2
   import dmem_pkg::*;
#(
   parameter int unsigned PRIO_MODE = PRIO_RR
) (
   input  logic valid0_i,
   input  logic valid1_i,
   input  logic last_owner_i,
   output logic winner_c_o,
   output logic any_c_o
);

   always_comb begin
      winner_c_o = 1'b0;
      any_c_o    = valid0_i | valid1_i;
      if (valid0_i && valid1_i) begin
         // On a tie the requester that did not own the last transaction goes next.
         winner_c_o = (PRIO_MODE == PRIO_FIXED) ? 1'b0 : ~last_owner_i;
      end else if (valid1_i) begin
         winner_c_o = 1'b1;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for a single-ported data memory: grant, one-cycle access, one-cycle response.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned PRIO_MODE = PRIO_RR
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              req0_rvalid,
   output logic [DATA_W-1:0] req0_rdata,
   input  logic              req1_valid,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              req1_rvalid,
   output logic [DATA_W-1:0] req1_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic              busy
);

   state_e              state_q, state_d;
   logic                cmd_we_q, cmd_we_d;
   logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
   logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
   logic                cmd_owner_q, cmd_owner_d;
   logic                last_owner_q, last_owner_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                winner_c;
   logic                any_valid_c;

   rr_pick2 #(
      .PRIO_MODE (PRIO_MODE)
   ) u_pick (
      .valid0_i     (req0_valid),
      .valid1_i     (req1_valid),
      .last_owner_i (last_owner_q),
      .winner_c_o   (winner_c),
      .any_c_o      (any_valid_c)
   );

   // last_owner resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cmd_we_q     <= 1'b0;
         cmd_addr_q   <= '0;
         cmd_wdata_q  <= '0;
         cmd_owner_q  <= 1'b0;
         last_owner_q <= 1'b1;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         cmd_we_q     <= cmd_we_d;
         cmd_addr_q   <= cmd_addr_d;
         cmd_wdata_q  <= cmd_wdata_d;
         cmd_owner_q  <= cmd_owner_d;
         last_owner_q <= last_owner_d;
         rdata_q      <= rdata_d;
      end
   end

   // Memory strobes decode straight from state so an async reset drops them at once.
   always_comb begin
      state_d        = state_q;
      cmd_we_d       = cmd_we_q;
      cmd_addr_d     = cmd_addr_q;
      cmd_wdata_d    = cmd_wdata_q;
      cmd_owner_d    = cmd_owner_q;
      last_owner_d   = last_owner_q;
      rdata_d        = rdata_q;
      req0_ready     = 1'b0;
      req1_ready     = 1'b0;
      req0_rvalid    = 1'b0;
      req1_rvalid    = 1'b0;
      req0_rdata     = '0;
      req1_rdata     = '0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_address    = '0;
      mem_write_data = '0;
      busy           = 1'b0;

      case (state_q)
         IDLE: begin
            if (!reset && any_valid_c) begin
               req0_ready  = ~winner_c;
               req1_ready  = winner_c;
               cmd_we_d    = winner_c ? req1_we    : req0_we;
               cmd_addr_d  = winner_c ? req1_addr  : req0_addr;
               cmd_wdata_d = winner_c ? req1_wdata : req0_wdata;
               cmd_owner_d = winner_c;
               state_d     = ACCESS;
            end
         end
         ACCESS: begin
            busy           = 1'b1;
            mem_address    = cmd_addr_q;
            mem_write      = cmd_we_q;
            mem_read       = ~cmd_we_q;
            mem_write_data = cmd_wdata_q;
            rdata_d        = cmd_we_q ? '0 : mem_read_data;
            last_owner_d   = cmd_owner_q;
            state_d        = RESP;
         end
         RESP: begin
            busy = 1'b1;
            if (cmd_owner_q) begin
               req1_rvalid = 1'b1;
               req1_rdata  = rdata_q;
            end else begin
               req0_rvalid = 1'b1;
               req0_rdata  = rdata_q;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
